fifo_flex: RTL
==============

Name: fifo_flex

Overview:
- Next-generation synchronous ready/valid FIFO. All DEPTH storage slots are usable, and DEPTH need not be a power of two.
- Adds an optional registered output stage, occupancy count, high-water mark and synchronous flush.
- Always-driven almost_full/almost_empty flags.
- Drop-in elastic buffer between streaming pipeline stages on a single clock domain.

Parameters:
- WIDTH, 8, data bits per entry (>=1).
- DEPTH, 8, storage-array entries (>=2, any integer).
- REG_OUT, 0, 0 = data_out read combinationally from array; 1 = data_out driven from a dedicated output register that adds one entry of capacity.
- ALMOST_FULL_THRESHOLD, 1, almost_full asserts when free slots <= this value.
- ALMOST_EMPTY_THRESHOLD, 1, almost_empty asserts when count <= this value.
- Derived (not a parameter): CAP = DEPTH+REG_OUT; CW = $clog2(CAP+1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all contents.
- ready_in  output  1  FIFO can accept an entry this cycle.
- valid_in  input  1  upstream presents data_in.
- data_in  input  WIDTH  write data.
- ready_out  input  1  downstream accepts data_out.
- valid_out  output  1  data_out holds valid head entry.
- data_out  output  WIDTH  head entry.
- count  output  CW  entries held, including the output register.
- high_water  output  CW  maximum count since last reset/flush.
- almost_full  output  1  count >= CAP-ALMOST_FULL_THRESHOLD.
- almost_empty  output  1  count <= ALMOST_EMPTY_THRESHOLD.

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - count=0, high_water=0, pointers=0, output register marked empty.
  - Outputs: valid_out=0, ready_in=1, almost_empty=1, almost_full=0 (for CAP>ALMOST_FULL_THRESHOLD).
  - Array and output data register are not reset; data_out is don't-care while valid_out=0.
- Handshakes: push = valid_in&&ready_in; pop = valid_out&&ready_out.
  - ready_in = (count<CAP). It depends only on state, never on ready_out: no push into a full FIFO even if a pop occurs in the same cycle.
  - valid_out = (count!=0).
- Pointers: wr_ptr/rd_ptr range 0..DEPTH-1 and wrap from DEPTH-1 to 0 explicitly. Power-of-two overflow is never relied on.
- count update per edge: push only +1, pop only -1, both or neither unchanged.
- high_water <= max(high_water, next count).
- Latency: an entry pushed at edge N is visible with valid_out=1 in the cycle after edge N for both REG_OUT values. No same-cycle combinational bypass from data_in to data_out.
- REG_OUT=0:
  - data_out = array[rd_ptr].
  - Push writes array[wr_ptr]; pop advances rd_ptr.
- REG_OUT=1 (output register OR plus valid bit ov; array holds count-ov entries):
  - If, after this edge's pop, OR would be empty and the array is empty, a push writes directly into OR (wr_ptr unchanged). Otherwise the push goes to the array.
  - If OR is empty or popped and the array is non-empty, OR loads array[rd_ptr] and rd_ptr advances. This happens in the same edge as the pop, so back-to-back pops stream at one entry per cycle.
  - Order is strictly FIFO across OR and the array.
- flush (synchronous, priority over push/pop):
  - Next edge sets count=0, high_water=0, pointers=0, ov=0.
  - A push presented in the flush cycle is discarded; a pop in the flush cycle is ignored.
- Simultaneous push+pop:
  - With count=0, only the push takes effect (pop impossible since valid_out=0).
  - With count=CAP, only the pop takes effect.
- Boundaries:
  - DEPTH=2 must work.
  - Thresholds >= CAP leave the corresponding flag permanently asserted; no error is raised.

Test Plan:
- DEPTH=5, REG_OUT=0: push 0x10..0x14 with ready_out=0 -> count 1..5, ready_in=0 after 5th push, almost_full=1 at count 4. Then pop 5 -> data 0x10..0x14 in order, count=0, valid_out=0.
- DEPTH=5, REG_OUT=1: push 6 entries 0xA0..0xA5 -> ready_in drops at count=6. Continuous pop with ready_out=1 -> 0xA0..0xA5 on 6 consecutive cycles, no bubble.
- Wrap: DEPTH=5, REG_OUT=0, 17 cycles of simultaneous push/pop from count=2 -> count stays 2, data order preserved across 3 pointer wraps, high_water=2 (or 3 if the first push precedes the first pop).
- Latency: empty FIFO, push 0x55 at edge N -> valid_out=1 and data_out=0x55 in the cycle after edge N, for both REG_OUT=0 and 1.
- Flush: count=4, assert flush with valid_in=1/data 0x77 -> next cycle count=0, high_water=0, valid_out=0, and 0x77 never appears at the output.
- Async reset mid-stream: assert reset between edges at count=3 -> count=0, valid_out=0, ready_in=1 immediately without a clock edge. After release, push 0x01 -> output 0x01 only.

Source files
------------

// File: rtl/fifo_flex.sv
// fifo_flex: single-clock ready/valid FIFO with any DEPTH,
// optional registered output stage, occupancy, high-water and flush.
module fifo_flex #(
    parameter int WIDTH                  = 8,
    parameter int DEPTH                  = 8,
    parameter int REG_OUT                = 0,
    parameter int ALMOST_FULL_THRESHOLD  = 1,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    output logic                                ready_in,
    input  logic                                valid_in,
    input  logic [WIDTH-1:0]                    data_in,
    input  logic                                ready_out,
    output logic                                valid_out,
    output logic [WIDTH-1:0]                    data_out,
    output logic [$clog2(DEPTH+REG_OUT+1)-1:0] count,
    output logic [$clog2(DEPTH+REG_OUT+1)-1:0] high_water,
    output logic                                almost_full,
    output logic                                almost_empty
);

    localparam int CAP = DEPTH + REG_OUT;
    localparam int CW  = $clog2(CAP + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Thresholds at or above CAP saturate, pinning the flag high.
    localparam int AF_FREE =
        (ALMOST_FULL_THRESHOLD >= CAP) ? CAP : ALMOST_FULL_THRESHOLD;
    localparam int AE_LVL =
        (ALMOST_EMPTY_THRESHOLD >= CAP) ? CAP : ALMOST_EMPTY_THRESHOLD;

    localparam logic [CW-1:0] CAP_C  = CW'(CAP);
    localparam logic [CW-1:0] AF_C   = CW'(AF_FREE);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LVL);
    localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             arr_we;
    logic             arr_re;
    logic [CW-1:0]    cnt_nxt;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    // ready_in depends on state only; a full FIFO never takes a push.
    assign ready_in     = (count < CAP_C);
    assign valid_out    = (count != '0);
    assign push         = valid_in && ready_in && !flush;
    assign pop          = valid_out && ready_out && !flush;
    assign almost_full  = ((CAP_C - count) <= AF_C);
    assign almost_empty = (count <= AE_C);

    // Occupancy after this edge's handshakes.
    always_comb begin
        cnt_nxt = count;
        if (push && !pop) begin
            cnt_nxt = count + CW'(1);
        end else if (pop && !push) begin
            cnt_nxt = count - CW'(1);
        end
    end

    // Occupancy and high-water tracking, flush clears both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            high_water <= '0;
        end else if (flush) begin
            count      <= '0;
            high_water <= '0;
        end else begin
            count <= cnt_nxt;
            if (cnt_nxt > high_water) begin
                high_water <= cnt_nxt;
            end
        end
    end

    // Array pointers advance on array writes/reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (arr_we) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (arr_re) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
        end
    end

    // Storage array write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[wr_ptr] <= data_in;
        end
    end

    generate
        if (REG_OUT == 0) begin : g_comb_out
            assign arr_we   = push;
            assign arr_re   = pop;
            assign data_out = mem[rd_ptr];
        end else begin : g_reg_out
            logic             ov;
            logic [WIDTH-1:0] or_q;
            logic [CW-1:0]    arr_cnt;
            logic             or_free;
            logic             arr_empty;
            logic             or_direct;

            // Route pushes/refills between the output register and array.
            always_comb begin
                arr_cnt   = count - CW'(ov);
                or_free   = !ov || pop;
                arr_empty = (arr_cnt == '0);
                or_direct = push && or_free && arr_empty;
                arr_we    = push && !or_direct;
                arr_re    = or_free && !arr_empty && !flush;
            end

            // Output register valid bit.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ov <= 1'b0;
                end else if (flush) begin
                    ov <= 1'b0;
                end else if (or_direct || arr_re) begin
                    ov <= 1'b1;
                end else if (pop) begin
                    ov <= 1'b0;
                end
            end

            // Output data register, refilled in the same edge as a pop.
            always_ff @(posedge clk) begin
                if (or_direct) begin
                    or_q <= data_in;
                end else if (arr_re) begin
                    or_q <= mem[rd_ptr];
                end
            end

            assign data_out = or_q;
        end
    endgenerate

endmodule
